div_unit: RTL and testbench
===========================

# div_unit

Multicycle signed 32-bit divider that sits directly downstream of the control unit. It starts on the control unit's `initDiv` pulse, divides operand register A by operand register B, and returns the remainder on `HI` and the quotient on `LO` for the HI/LO registers. It reports a divide-by-zero condition back to the control unit so the control unit can take the `DIV_BY_ZERO` exception path. It also raises a completion pulse that releases the control unit from its `DIV_2` wait state.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width. Only 32 is verified.

Ports:
- `clk`  input  1  system clock, rising-edge.
- `reset`  input  1  reset, asynchronous, active-low.
- `initDiv`  input  1  start request from the control unit. Sampled only in IDLE.
- `A`  input  32  dividend, two's complement (A register output).
- `B`  input  32  divisor, two's complement (B register output).
- `HI`  output  32  remainder of the last successful division.
- `LO`  output  32  quotient of the last successful division.
- `busy`  output  1  high whenever the state is not IDLE.
- `divDone`  output  1  one-cycle pulse when `HI`/`LO` are updated.
- `divZero`  output  1  one-cycle pulse when a start was rejected because B == 0.

## Operation
- States: IDLE, RUN, FIX, DONE. State is held in registers, and all outputs are registered or decoded from state.
- **IDLE**
  - If `initDiv`=1 and B == 0: set `divZero`=1 for one cycle and stay in IDLE. `HI`/`LO` are unchanged and no iteration runs.
  - If `initDiv`=1 and B != 0:
    - Capture sA = A[31] and sB = B[31].
    - Capture magnitudes |A| and |B| as 32-bit unsigned values (|0x80000000| = 0x80000000).
    - Clear the 33-bit partial remainder R and the quotient register Q.
    - Set the counter to 0 and go to RUN.
  - If `initDiv`=0: stay in IDLE.
- **RUN**: one restoring-division step per cycle.
  - Shift {R, Q} left by 1, bringing the next dividend MSB into R[0].
  - If R >= |B|: set R = R − |B| and Q[0] = 1.
  - After 32 steps (counter 0..31), go to FIX.
- **FIX**
  - Set `LO` = (sA ^ sB) ? −Q : Q.
  - Set `HI` = sA ? −R[31:0] : R[31:0].
  - Go to DONE.
- **DONE**: `divDone`=1 for this cycle only, then go to IDLE.
- Arithmetic rules:
  - The quotient truncates toward zero.
  - The remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives `LO`=0x80000000 and `HI`=0, with no flag raised (overflow is the control unit's concern).
- `initDiv` while `busy`=1 is ignored. The operation in flight is not disturbed, and `A`/`B` may change freely after capture.
- Reset (asynchronous, `reset`=0), including in the middle of an operation:
  - Go to IDLE.
  - `HI`=0, `LO`=0, `busy`=0, `divDone`=0, `divZero`=0.
  - Counter and internal registers are cleared.
  - No `divDone` is produced for the aborted operation.

## Timing
- Edge E0 samples `initDiv`=1 in IDLE. Count edges from there.
- Normal division (B != 0):
  - `busy` is high from after E0 until after E34.
  - E1..E32 perform the 32 RUN steps.
  - E33 performs FIX: `HI`/`LO` take new values after E33.
  - `divDone` is high for the single cycle between E33 and E34.
  - The unit is back in IDLE after E34, and a new `initDiv` can be accepted at E35.
  - Latency from start to `divDone` is 34 cycles.
- Divide-by-zero:
  - `divZero` is high for the single cycle between E0 and E1.
  - `busy` stays 0.
  - Back-to-back zero starts produce back-to-back pulses.
- `HI`/`LO` hold their values between operations and change only at the FIX edge.
- `divDone` and `divZero` are never high in the same cycle.

## Test plan
- A=100, B=7, pulse `initDiv` → `divDone` 34 cycles later; `LO`=14, `HI`=2; `busy` high for exactly 34 cycles.
- A=−7 (0xFFFFFFF9), B=2 → `LO`=0xFFFFFFFD (−3), `HI`=0xFFFFFFFF (−1). Then A=7, B=−2 → `LO`=−3, `HI`=1.
- A=0x80000000, B=0xFFFFFFFF → `LO`=0x80000000, `HI`=0, `divDone` pulses, `divZero` stays 0.
- After a 100/7 result, start with A=5, B=0 → `divZero`=1 for one cycle, `busy`=0, `HI`=2 and `LO`=14 unchanged, `divDone` never asserts.
- Start 100/7, then at the 10th RUN cycle pulse `initDiv` with A=1, B=1 → ignored; result is still 14/2.
- Start 100/7, then assert `reset`=0 asynchronously mid-RUN → all outputs 0 immediately. Release reset and run 9/3 → `LO`=3, `HI`=0.

Source files
------------

// File: rtl/div_if.sv
// div_if: bundles the control-unit <-> divider signals.
//   master (control unit): drives initDiv, A, B; receives HI, LO, busy, divDone, divZero
//   slave  (divider):      receives initDiv, A, B; drives HI, LO, busy, divDone, divZero
interface div_if #(parameter int WIDTH = 32);
  logic             initDiv;
  logic [WIDTH-1:0] A, B, HI, LO;
  logic             busy, divDone, divZero;
  modport master(output initDiv, A, B, input HI, LO, busy, divDone, divZero);
  modport slave(input initDiv, A, B, output HI, LO, busy, divDone, divZero);
endinterface

// File: rtl/div_unit.sv
// div_unit: multicycle signed restoring divider, remainder on HI, quotient on LO.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : div_if slave (initDiv/A/B in; HI/LO/busy/divDone/divZero out)
module div_unit #(parameter int WIDTH = 32) (
  input logic  clk,
  input logic  reset,
  div_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH:0]   r_q, r_d, r_sh;
  logic [WIDTH-1:0] q_q, q_d, a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sa_q, sa_d, sb_q, sb_d, zero_q, zero_d, start, ge;
  always_comb begin
    start   = state_q == IDLE && bus.initDiv;
    // a_q holds the dividend magnitude and shifts out MSB-first into the remainder
    r_sh    = (r_q << 1) | {{WIDTH{1'b0}}, a_q[WIDTH-1]};
    ge      = r_sh >= {1'b0, b_q};
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    a_d     = a_q;
    b_d     = b_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    zero_d  = start && bus.B == '0;
    case (state_q)
      IDLE: if (start && bus.B != '0) begin
        sa_d    = bus.A[WIDTH-1];
        sb_d    = bus.B[WIDTH-1];
        a_d     = bus.A[WIDTH-1] ? -bus.A : bus.A;
        b_d     = bus.B[WIDTH-1] ? -bus.B : bus.B;
        r_d     = '0;
        q_d     = '0;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        r_d     = ge ? r_sh - {1'b0, b_q} : r_sh;
        q_d     = {q_q[WIDTH-2:0], ge};
        a_d     = a_q << 1;
        cnt_d   = cnt_q + CW'(1);
        state_d = cnt_q == CW'(WIDTH - 1) ? FIX : RUN;
      end
      FIX: begin
        lo_d    = (sa_q ^ sb_q) ? -q_q : q_q;
        hi_d    = sa_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      zero_q  <= zero_d;
    end
  end
  assign bus.HI      = hi_q;
  assign bus.LO      = lo_q;
  assign bus.busy    = state_q != IDLE;
  assign bus.divDone = state_q == DONE;
  assign bus.divZero = zero_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized self-checking bench for div_unit against a 64-bit arithmetic model.
module tb_div_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  div_if bus();
  div_unit dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic model(input logic [31:0] a, input logic [31:0] b, output logic [31:0] q, output logic [31:0] r);
    longint la, lb;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    q  = 32'(la / lb);
    r  = 32'(la % lb);
  endtask
  task automatic run(input logic [31:0] a, input logic [31:0] b, input int poke, input string tag);
    logic [31:0] eq, er;
    int cyc = 0, bcnt = 0;
    bit done = 0, zflag = 0;
    model(a, b, eq, er);
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.initDiv = 1'b1;
    @(posedge clk);
    #1 bus.initDiv = 1'b0;
    bus.A = $urandom;
    bus.B = $urandom;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == poke) begin
        bus.A = 32'd1;
        bus.B = 32'd1;
        bus.initDiv = 1'b1;
      end else bus.initDiv = 1'b0;
      bcnt += int'(bus.busy);
      zflag |= bus.divZero;
      done = bus.divDone;
    end
    check({tag, " latency"}, cyc, 34);
    check({tag, " busy_cycles"}, bcnt, 34);
    check({tag, " LO"}, bus.LO, eq);
    check({tag, " HI"}, bus.HI, er);
    check({tag, " divZero"}, {31'b0, zflag}, 0);
    @(negedge clk);
    check({tag, " idle"}, {30'b0, bus.busy, bus.divDone}, 0);
  endtask
  initial begin
    logic [31:0] ra, rb;
    bus.initDiv = 1'b0;
    bus.A = '0;
    bus.B = '0;
    #12;
    check("rst HI", bus.HI, 0);
    check("rst LO", bus.LO, 0);
    check("rst flags", {29'b0, bus.busy, bus.divDone, bus.divZero}, 0);
    @(negedge clk);
    reset = 1'b1;
    run(32'd100, 32'd7, 0, "100/7");
    run(32'hFFFFFFF9, 32'd2, 0, "-7/2");
    run(32'd7, 32'hFFFFFFFE, 0, "7/-2");
    run(32'h80000000, 32'hFFFFFFFF, 0, "min/-1");
    run(32'h80000000, 32'h80000000, 0, "min/min");
    run(32'd0, 32'd5, 0, "0/5");
    run(32'd100, 32'd7, 0, "100/7b");
    @(negedge clk);
    bus.A = 32'd5;
    bus.B = 32'd0;
    bus.initDiv = 1'b1;
    @(negedge clk);
    check("zero pulse", {29'b0, bus.busy, bus.divDone, bus.divZero}, 1);
    @(negedge clk);
    check("zero b2b", {29'b0, bus.busy, bus.divDone, bus.divZero}, 1);
    bus.initDiv = 1'b0;
    @(negedge clk);
    check("zero clear", {29'b0, bus.busy, bus.divDone, bus.divZero}, 0);
    check("zero HI kept", bus.HI, 2);
    check("zero LO kept", bus.LO, 14);
    run(32'd100, 32'd7, 10, "ignored start");
    @(negedge clk);
    bus.A = 32'd100;
    bus.B = 32'd7;
    bus.initDiv = 1'b1;
    @(posedge clk);
    #1 bus.initDiv = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async rst HI", bus.HI, 0);
    check("async rst LO", bus.LO, 0);
    check("async rst flags", {29'b0, bus.busy, bus.divDone, bus.divZero}, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("no stale done", {30'b0, bus.busy, bus.divDone}, 0);
    run(32'd9, 32'd3, 0, "9/3");
    for (int i = 0; i < 30; i++) begin
      ra = (i % 7 == 0) ? 32'h80000000 : $urandom;
      rb = (i % 3 == 0) ? 32'($signed($urandom_range(0, 40)) - 20) : $urandom;
      if (i % 4 == 0) ra = 32'($signed($urandom_range(0, 2000)) - 1000);
      if (rb == 0) rb = 32'hFFFFFFFF;
      run(ra, rb, (i % 5 == 0) ? int'($urandom_range(1, 30)) : 0, $sformatf("rnd%0d", i));
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
